// File: rtl/vector_list_sequencer.sv
// Frame-level display-list walker: fetches 18-bit MOVE/DRAW/END/NOP words and drives the line drawer.
// Define VECTOR_WDOG_EN to add the fetch-limit / drawer-stall watchdog (MAX_WORDS, wdog_err).
module vector_list_sequencer #(
    parameter int unsigned ADDRESSWIDTH = 16,
    parameter int unsigned DATAWIDTH    = 18,
    parameter int unsigned DAC_WIDTH    = 8,
    parameter int unsigned CEASE_CYCLES = 3
`ifdef VECTOR_WDOG_EN
    ,
    parameter int unsigned MAX_WORDS    = 4096
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [ADDRESSWIDTH-1:0] base_addr,
    output logic [ADDRESSWIDTH-1:0] mem_addr,
    output logic                    mem_rd,
    input  logic [DATAWIDTH-1:0]    mem_data,
    output logic                    ld_start,
    output logic [DAC_WIDTH-1:0]    ld_x0,
    output logic [DAC_WIDTH-1:0]    ld_y0,
    output logic [DAC_WIDTH-1:0]    ld_x1,
    output logic [DAC_WIDTH-1:0]    ld_y1,
    input  logic                    ld_done,
    output logic [DAC_WIDTH-1:0]    pos_x,
    output logic [DAC_WIDTH-1:0]    pos_y,
    output logic                    blank,
    output logic                    busy,
    output logic                    frame_done
`ifdef VECTOR_WDOG_EN
    ,
    output logic                    wdog_err
`endif
);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StDecode, StWaitLd, StCease} state_t;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_DRAW = 2'b01;
    localparam logic [1:0] OP_END  = 2'b10;

    // A zero dwell still spends one cycle in CEASE.
    localparam int unsigned CEASE_N = (CEASE_CYCLES == 0) ? 1 : CEASE_CYCLES;
    localparam int unsigned CW      = $clog2(CEASE_N + 1);

    state_t                  r_state, w_state_nxt;
    logic [ADDRESSWIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATAWIDTH-1:0]    r_word, w_word_nxt;
    logic                    r_ld_start, w_ld_start_nxt;
    logic [DAC_WIDTH-1:0]    r_ld_x0, r_ld_y0, r_ld_x1, r_ld_y1;
    logic [DAC_WIDTH-1:0]    w_ld_x0_nxt, w_ld_y0_nxt, w_ld_x1_nxt, w_ld_y1_nxt;
    logic [DAC_WIDTH-1:0]    r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
    logic                    r_blank, w_blank_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_frame_done, w_frame_done_nxt;
    logic [CW-1:0]           r_cease_cnt, w_cease_cnt_nxt;
    logic                    w_mem_rd;
    logic [1:0]              w_op;
    logic [DAC_WIDTH-1:0]    w_x, w_y;

`ifdef VECTOR_WDOG_EN
    localparam int unsigned FCW = $clog2(MAX_WORDS + 1);
    logic [FCW-1:0] r_fetch_cnt, w_fetch_cnt_nxt;
    logic [15:0]    r_stall_cnt, w_stall_cnt_nxt;
    logic           r_wdog_err, w_wdog_err_nxt;
    logic           w_abort;
`endif

    assign w_op = r_word[17:16];
    assign w_x  = DAC_WIDTH'(r_word[15:8]);
    assign w_y  = DAC_WIDTH'(r_word[7:0]);

    always_comb begin
        w_state_nxt      = r_state;
        w_mem_addr_nxt   = r_mem_addr;
        w_word_nxt       = r_word;
        w_ld_start_nxt   = 1'b0;
        w_ld_x0_nxt      = r_ld_x0;
        w_ld_y0_nxt      = r_ld_y0;
        w_ld_x1_nxt      = r_ld_x1;
        w_ld_y1_nxt      = r_ld_y1;
        w_pos_x_nxt      = r_pos_x;
        w_pos_y_nxt      = r_pos_y;
        w_blank_nxt      = r_blank;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
        w_cease_cnt_nxt  = r_cease_cnt;
        w_mem_rd         = 1'b0;
`ifdef VECTOR_WDOG_EN
        w_fetch_cnt_nxt  = r_fetch_cnt;
        w_stall_cnt_nxt  = r_stall_cnt;
        w_wdog_err_nxt   = r_wdog_err;
        w_abort          = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (frame_start) begin
                    w_mem_addr_nxt = base_addr;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = StFetch;
`ifdef VECTOR_WDOG_EN
                    w_fetch_cnt_nxt = '0;
                    w_wdog_err_nxt  = 1'b0;
`endif
                end
            end
            StFetch: begin
`ifdef VECTOR_WDOG_EN
                if (r_fetch_cnt >= FCW'(MAX_WORDS)) begin
                    w_abort = 1'b1;
                end else begin
                    w_mem_rd        = 1'b1;
                    w_fetch_cnt_nxt = r_fetch_cnt + 1'b1;
                    w_state_nxt     = StWait;
                end
`else
                w_mem_rd    = 1'b1;
                w_state_nxt = StWait;
`endif
            end
            StWait: begin
                w_word_nxt  = mem_data;
                w_state_nxt = StDecode;
            end
            StDecode: begin
                case (w_op)
                    OP_MOVE: begin
                        w_pos_x_nxt     = w_x;
                        w_pos_y_nxt     = w_y;
                        w_cease_cnt_nxt = '0;
                        w_state_nxt     = StCease;
                    end
                    OP_DRAW: begin
                        w_ld_x0_nxt    = r_pos_x;
                        w_ld_y0_nxt    = r_pos_y;
                        w_ld_x1_nxt    = w_x;
                        w_ld_y1_nxt    = w_y;
                        w_ld_start_nxt = 1'b1;
                        w_blank_nxt    = 1'b0;
                        w_state_nxt    = StWaitLd;
`ifdef VECTOR_WDOG_EN
                        w_stall_cnt_nxt = '0;
`endif
                    end
                    OP_END: begin
                        w_frame_done_nxt = 1'b1;
                        w_busy_nxt       = 1'b0;
                        w_blank_nxt      = 1'b1;
                        w_state_nxt      = StIdle;
                    end
                    default: begin
                        w_mem_addr_nxt = r_mem_addr + 1'b1;
                        w_state_nxt    = StFetch;
                    end
                endcase
            end
            StWaitLd: begin
                if (ld_done) begin
                    w_pos_x_nxt     = r_ld_x1;
                    w_pos_y_nxt     = r_ld_y1;
                    w_blank_nxt     = 1'b1;
                    w_cease_cnt_nxt = '0;
                    w_state_nxt     = StCease;
                end
`ifdef VECTOR_WDOG_EN
                else if (r_stall_cnt == 16'hFFFF) begin
                    w_abort = 1'b1;
                end else begin
                    w_stall_cnt_nxt = r_stall_cnt + 1'b1;
                end
`endif
            end
            StCease: begin
                if (r_cease_cnt == CW'(CEASE_N - 1)) begin
                    w_mem_addr_nxt = r_mem_addr + 1'b1;
                    w_state_nxt    = StFetch;
                end else begin
                    w_cease_cnt_nxt = r_cease_cnt + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
`ifdef VECTOR_WDOG_EN
        if (w_abort) begin
            w_state_nxt      = StIdle;
            w_busy_nxt       = 1'b0;
            w_blank_nxt      = 1'b1;
            w_frame_done_nxt = 1'b1;
            w_wdog_err_nxt   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_mem_addr   <= '0;
            r_word       <= '0;
            r_ld_start   <= 1'b0;
            r_ld_x0      <= '0;
            r_ld_y0      <= '0;
            r_ld_x1      <= '0;
            r_ld_y1      <= '0;
            r_pos_x      <= '0;
            r_pos_y      <= '0;
            r_blank      <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_cease_cnt  <= '0;
`ifdef VECTOR_WDOG_EN
            r_fetch_cnt  <= '0;
            r_stall_cnt  <= '0;
            r_wdog_err   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_word       <= w_word_nxt;
            r_ld_start   <= w_ld_start_nxt;
            r_ld_x0      <= w_ld_x0_nxt;
            r_ld_y0      <= w_ld_y0_nxt;
            r_ld_x1      <= w_ld_x1_nxt;
            r_ld_y1      <= w_ld_y1_nxt;
            r_pos_x      <= w_pos_x_nxt;
            r_pos_y      <= w_pos_y_nxt;
            r_blank      <= w_blank_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_cease_cnt  <= w_cease_cnt_nxt;
`ifdef VECTOR_WDOG_EN
            r_fetch_cnt  <= w_fetch_cnt_nxt;
            r_stall_cnt  <= w_stall_cnt_nxt;
            r_wdog_err   <= w_wdog_err_nxt;
`endif
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_rd     = w_mem_rd;
    assign ld_start   = r_ld_start;
    assign ld_x0      = r_ld_x0;
    assign ld_y0      = r_ld_y0;
    assign ld_x1      = r_ld_x1;
    assign ld_y1      = r_ld_y1;
    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign blank      = r_blank;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
`ifdef VECTOR_WDOG_EN
    assign wdog_err   = r_wdog_err;
`endif

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Scoreboard bench for vector_list_sequencer: a list-walking reference model queues expected
// reads, segments and frame ends; a negedge monitor pops and compares them.
module tb_vector_list_sequencer;

    localparam int CEASE     = 3;
    localparam int CEASE_EFF = (CEASE == 0) ? 1 : CEASE;
`ifdef VECTOR_WDOG_EN
    localparam int MAXW   = 4;
    localparam int MAXLEN = 3;
`else
    localparam int MAXW   = 1 << 30;
    localparam int MAXLEN = 10;
`endif

    logic        clk, rst, frame_start, mem_rd, ld_start, ld_done, blank, busy, frame_done;
    logic [15:0] base_addr, mem_addr;
    logic [17:0] mem_data;
    logic [7:0]  ld_x0, ld_y0, ld_x1, ld_y1, pos_x, pos_y;
`ifdef VECTOR_WDOG_EN
    logic        wdog_err;
`endif

    vector_list_sequencer #(
        .ADDRESSWIDTH(16),
        .DATAWIDTH   (18),
        .DAC_WIDTH   (8),
        .CEASE_CYCLES(CEASE)
`ifdef VECTOR_WDOG_EN
        ,
        .MAX_WORDS   (MAXW)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .base_addr  (base_addr),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .ld_start   (ld_start),
        .ld_x0      (ld_x0),
        .ld_y0      (ld_y0),
        .ld_x1      (ld_x1),
        .ld_y1      (ld_y1),
        .ld_done    (ld_done),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .blank      (blank),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef VECTOR_WDOG_EN
        ,
        .wdog_err   (wdog_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous vector RAM: data valid one cycle after mem_rd.
    logic [17:0] mem [0:65535];
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    typedef struct {logic [15:0] addr; int gap;} rd_t;
    typedef struct {logic [7:0] x0; logic [7:0] y0; logic [7:0] x1; logic [7:0] y1;} seg_t;
    typedef struct {logic [7:0] px; logic [7:0] py; logic wd;} frm_t;

    rd_t  q_rd[$];
    seg_t q_seg[$];
    frm_t q_frm[$];
    seg_t cur_seg;
    logic [7:0] m_px, m_py;
    int   n_tests, n_fail, frames_seen, ld_delay, cyc, last_rd;
    bit   in_seg, drawer_hold, late_pulse;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the list with the opcode rules, recording what the DUT must produce.
    task automatic model_frame(input logic [15:0] base);
        logic [15:0] a;
        logic [17:0] wd;
        int gap, n;
        bit done;
        a = base; gap = -1; n = 0; done = 0;
        while (!done) begin
            if (n == MAXW) begin
                q_frm.push_back('{m_px, m_py, 1'b1});
                done = 1;
            end else begin
                q_rd.push_back('{a, gap});
                n++;
                wd = mem[a];
                case (wd[17:16])
                    2'b00: begin m_px = wd[15:8]; m_py = wd[7:0]; gap = 3 + CEASE_EFF; a++; end
                    2'b01: begin
                        q_seg.push_back('{m_px, m_py, wd[15:8], wd[7:0]});
                        m_px = wd[15:8]; m_py = wd[7:0]; gap = -1; a++;
                    end
                    2'b10: begin q_frm.push_back('{m_px, m_py, 1'b0}); done = 1; end
                    default: begin gap = 3; a++; end
                endcase
            end
        end
    endtask

    // Monitor
    initial begin
        rd_t  r;
        frm_t f;
        cyc = 0; last_rd = 0; in_seg = 0; frames_seen = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_seg = 0;
            end else begin
                if (mem_rd) begin
                    check("rd_expected", q_rd.size() != 0, 1);
                    if (q_rd.size() != 0) begin
                        r = q_rd.pop_front();
                        check("rd_addr", mem_addr, r.addr);
                        if (r.gap >= 0) check("rd_gap", cyc - last_rd, r.gap);
                    end
                    last_rd = cyc;
                end
                if (ld_start) begin
                    check("seg_expected", q_seg.size() != 0, 1);
                    if (q_seg.size() != 0) cur_seg = q_seg.pop_front();
                    in_seg = 1;
                end
                check("blank", blank, !in_seg);
                if (in_seg)
                    check("ld_coords", {ld_x0, ld_y0, ld_x1, ld_y1},
                          {cur_seg.x0, cur_seg.y0, cur_seg.x1, cur_seg.y1});
                if (ld_done && in_seg) in_seg = 0;
                if (frame_done) begin
                    frames_seen++;
                    check("frm_expected", q_frm.size() != 0, 1);
                    if (q_frm.size() != 0) begin
                        f = q_frm.pop_front();
                        check("final_pos", {pos_x, pos_y}, {f.px, f.py});
`ifdef VECTOR_WDOG_EN
                        check("wdog_err", wdog_err, f.wd);
`endif
                    end
                    check("busy_at_done", busy, 0);
                end
            end
        end
    end

    // Stub line drawer
    initial begin
        bit lp_prev;
        ld_done = 1'b0; lp_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst && ld_start && !drawer_hold) begin
                repeat (ld_delay) @(posedge clk);
                #1 ld_done = 1'b1;
                @(posedge clk);
                #1 ld_done = 1'b0;
            end else if (late_pulse && !lp_prev) begin
                @(posedge clk);
                #1 ld_done = 1'b1;
                @(posedge clk);
                #1 ld_done = 1'b0;
            end
            lp_prev = late_pulse;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic clear_model();
        q_rd.delete(); q_seg.delete(); q_frm.delete();
        m_px = 8'd0; m_py = 8'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        clear_model();
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_addr", mem_addr, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_ld", {ld_start, ld_x0, ld_y0, ld_x1, ld_y1}, 0);
        check("rst_pos", {pos_x, pos_y}, 0);
        check("rst_flags", {blank, busy, frame_done}, 3'b100);
    endtask

    task automatic run_frame(input logic [15:0] base, input bit mid);
        int target;
        bit ok;
        target = frames_seen + 1;
        model_frame(base);
        @(posedge clk); #1 frame_start = 1'b1; base_addr = base;
        @(posedge clk); #1 frame_start = 1'b0;
        check("busy_rise", busy, 1);
`ifdef VECTOR_WDOG_EN
        check("wdog_clear", wdog_err, 0);
`endif
        if (mid) begin
            repeat (3) @(posedge clk);
            #1 frame_start = 1'b1; base_addr = 16'h2000;
            @(posedge clk); #1 frame_start = 1'b0;
            check("busy_hold", busy, 1);
        end
        ok = 0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk); #1;
            if (frames_seen >= target) begin ok = 1; break; end
        end
        check("frame_timeout", ok, 1);
        repeat (3) @(negedge clk);
        check("rd_left", q_rd.size(), 0);
        check("seg_left", q_seg.size(), 0);
        check("frm_left", q_frm.size(), 0);
        if (!ok) do_reset();
    endtask

    initial begin
        logic [15:0] b;
        logic [1:0]  op;
        int len;
        bit ok;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; frame_start = 1'b0; base_addr = 16'h0;
        drawer_hold = 0; late_pulse = 0; ld_delay = 5;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        // MOVE, DRAW, END at 0x0010 with a 5-cycle drawer
        mem[16'h0010] = {2'b00, 8'd10, 8'd20};
        mem[16'h0011] = {2'b01, 8'd200, 8'd20};
        mem[16'h0012] = {2'b10, 16'h0};
        run_frame(16'h0010, 0);
        check("t1_pos", {pos_x, pos_y}, {8'd200, 8'd20});
        check("t1_frames", frames_seen, 1);

        // MOVE then END: the rd_gap check enforces the CEASE dwell
        mem[16'h0100] = {2'b00, 8'd33, 8'd44};
        mem[16'h0101] = {2'b10, 16'h0};
        run_frame(16'h0100, 0);

        // NOP, NOP, END across the address wrap, with an ignored mid-frame frame_start
        mem[16'hFFFE] = {2'b11, 16'h1234};
        mem[16'hFFFF] = {2'b11, 16'h5678};
        mem[16'h0000] = {2'b10, 16'h0};
        run_frame(16'hFFFE, 1);

        // Asynchronous reset during WAIT_LD
        mem[16'h0200] = {2'b01, 8'd50, 8'd60};
        mem[16'h0201] = {2'b10, 16'h0};
        drawer_hold = 1;
        model_frame(16'h0200);
        @(posedge clk); #1 frame_start = 1'b1; base_addr = 16'h0200;
        @(posedge clk); #1 frame_start = 1'b0;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ld_start) begin ok = 1; break; end
        end
        check("ld_start_seen", ok, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        late_pulse = 1;
        repeat (5) @(negedge clk);
        check("late_done_busy", busy, 0);
        check("late_done_blank", blank, 1);
        check("late_done_pos", {pos_x, pos_y}, 0);
        late_pulse = 0;
        drawer_hold = 0; ld_delay = 3;
        run_frame(16'h0200, 0);
        check("post_rst_pos", {pos_x, pos_y}, {8'd50, 8'd60});

`ifdef VECTOR_WDOG_EN
        for (int i = 0; i < 6; i++) mem[16'h0300 + 16'(i)] = {2'b11, 16'h0};
        run_frame(16'h0300, 0);
        mem[16'h0310] = {2'b10, 16'h0};
        run_frame(16'h0310, 0);
`endif

        // Randomized lists
        for (int f = 0; f < 12; f++) begin
            b   = 16'($urandom_range(0, 65535));
            len = $urandom_range(1, MAXLEN);
            for (int i = 0; i < len; i++) begin
                op = 2'($urandom_range(0, 2));
                if (op == 2'b10) op = 2'b11;
                mem[b + 16'(i)] = {op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            end
            mem[b + 16'(len)] = {2'b10, 16'h0};
            ld_delay = $urandom_range(1, 6);
            run_frame(b, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
